// File: rtl/dm_pkg.sv
// Shared constants for the 1-to-5 write distributor: bus/select widths and
// the fixed slot assignment of the five datapath consumers.
package dm_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned NCH   = 5;
  localparam int unsigned SEL_W = 3;

  localparam int unsigned SLOT_PC  = 0;
  localparam int unsigned SLOT_IR  = 1;
  localparam int unsigned SLOT_RF  = 2;
  localparam int unsigned SLOT_MAR = 3;
  localparam int unsigned SLOT_MDR = 4;

endpackage

// File: rtl/dm_slot.sv
// One holding slot: registered word, valid flag cleared by ack, and a sticky
// overrun flag raised when a still-unconsumed word is overwritten.
module dm_slot
  import dm_pkg::*;
#(
  parameter int unsigned DW = WIDTH
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          wr,
  input  logic          ack,
  input  logic          clr,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q,
  output logic          v,
  output logic          ovr
);

  logic [DW-1:0] r_q;
  logic          r_v;
  logic          r_ovr;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_q   <= '0;
      r_v   <= 1'b0;
      r_ovr <= 1'b0;
    end else begin
      if (wr) begin
        r_q <= d;
      end
      // A write beats a same-cycle ack; ack only drops valid when idle.
      if (wr) begin
        r_v <= 1'b1;
      end else if (ack) begin
        r_v <= 1'b0;
      end
      // A new overrun beats a same-cycle clear.
      if (wr && r_v && !ack) begin
        r_ovr <= 1'b1;
      end else if (clr) begin
        r_ovr <= 1'b0;
      end
    end
  end

  assign q   = r_q;
  assign v   = r_v;
  assign ovr = r_ovr;

endmodule

// File: rtl/dm1_5_reg.sv
// Registered 1-to-5 write distributor: decodes the select into one slot write,
// flags out-of-range selects and captures the first bad select value.
module dm1_5_reg
  import dm_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [WIDTH-1:0] I,
  input  logic [SEL_W-1:0] S,
  input  logic             WE,
  input  logic [NCH-1:0]   ACK,
  input  logic             CLR_ERR,
  output logic [WIDTH-1:0] O0,
  output logic [WIDTH-1:0] O1,
  output logic [WIDTH-1:0] O2,
  output logic [WIDTH-1:0] O3,
  output logic [WIDTH-1:0] O4,
  output logic [NCH-1:0]   V,
  output logic [NCH-1:0]   OVR,
  output logic             ERR,
  output logic [SEL_W-1:0] ERR_SEL
);

  logic [NCH-1:0]   w_wr;
  logic [NCH-1:0]   w_v;
  logic [NCH-1:0]   w_ovr;
  logic [WIDTH-1:0] w_q [NCH];
  logic             w_bad;
  logic             r_err;
  logic [SEL_W-1:0] r_err_sel;

  assign w_bad = WE && (S >= SEL_W'(NCH));

  always_comb begin
    w_wr = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (WE && (S == SEL_W'(k))) begin
        w_wr[k] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_slot
    dm_slot #(.DW(WIDTH)) u_slot (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .wr      (w_wr[g]),
      .ack     (ACK[g]),
      .clr     (CLR_ERR),
      .d       (I),
      .q       (w_q[g]),
      .v       (w_v[g]),
      .ovr     (w_ovr[g])
    );
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_err     <= 1'b0;
      r_err_sel <= '0;
    end else begin
      if (w_bad) begin
        r_err <= 1'b1;
      end else if (CLR_ERR) begin
        r_err <= 1'b0;
      end
      // Capture only the first bad select, unless this cycle also clears.
      if (w_bad && (!r_err || CLR_ERR)) begin
        r_err_sel <= S;
      end else if (CLR_ERR) begin
        r_err_sel <= '0;
      end
    end
  end

  assign O0      = w_q[SLOT_PC];
  assign O1      = w_q[SLOT_IR];
  assign O2      = w_q[SLOT_RF];
  assign O3      = w_q[SLOT_MAR];
  assign O4      = w_q[SLOT_MDR];
  assign V       = w_v;
  assign OVR     = w_ovr;
  assign ERR     = r_err;
  assign ERR_SEL = r_err_sel;

endmodule

// File: tb/tb_dm1_5_reg.sv
// Directed scoreboard bench for dm1_5_reg: each stimulus step pushes the
// hand-derived output state; a monitor pops and compares after the edge.
module tb_dm1_5_reg;

  logic        CLK;
  logic        RESET_N;
  logic [15:0] I;
  logic [2:0]  S;
  logic        WE;
  logic [4:0]  ACK;
  logic        CLR_ERR;
  logic [15:0] O0, O1, O2, O3, O4;
  logic [4:0]  V;
  logic [4:0]  OVR;
  logic        ERR;
  logic [2:0]  ERR_SEL;

  typedef struct packed {
    logic [4:0][15:0] o;
    logic [4:0]       v;
    logic [4:0]       ovr;
    logic             err;
    logic [2:0]       esel;
  } exp_t;

  exp_t e;
  exp_t sb_q[$];
  int   id_q[$];
  int   step_id;
  int   n_checks;
  int   n_fail;

  dm1_5_reg u_dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .I       (I),
    .S       (S),
    .WE      (WE),
    .ACK     (ACK),
    .CLR_ERR (CLR_ERR),
    .O0      (O0),
    .O1      (O1),
    .O2      (O2),
    .O3      (O3),
    .O4      (O4),
    .V       (V),
    .OVR     (OVR),
    .ERR     (ERR),
    .ERR_SEL (ERR_SEL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input int id, input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL step%0d %s: got %h expected %h", id, name, act, req);
    end
  endtask

  // Monitor: outputs settle one time unit after a clock edge or async reset.
  initial begin
    exp_t x;
    int   id;
    forever begin
      @(posedge CLK or negedge RESET_N);
      #1;
      if (sb_q.size() > 0) begin
        x  = sb_q.pop_front();
        id = id_q.pop_front();
        chk(id, "O0",      O0,            x.o[0]);
        chk(id, "O1",      O1,            x.o[1]);
        chk(id, "O2",      O2,            x.o[2]);
        chk(id, "O3",      O3,            x.o[3]);
        chk(id, "O4",      O4,            x.o[4]);
        chk(id, "V",       {11'd0, V},    {11'd0, x.v});
        chk(id, "OVR",     {11'd0, OVR},  {11'd0, x.ovr});
        chk(id, "ERR",     {15'd0, ERR},  {15'd0, x.err});
        chk(id, "ERR_SEL", {13'd0, ERR_SEL}, {13'd0, x.esel});
      end
    end
  end

  // Called at a falling edge: drive one cycle of inputs and queue expectation.
  task automatic step(input logic we, input logic [2:0] s, input logic [15:0] d,
                      input logic [4:0] ack, input logic clr);
    WE      = we;
    S       = s;
    I       = d;
    ACK     = ack;
    CLR_ERR = clr;
    step_id++;
    sb_q.push_back(e);
    id_q.push_back(step_id);
    @(negedge CLK);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    step_id  = 0;
    e        = '0;
    RESET_N  = 1'b0;
    WE = 1'b0; S = '0; I = '0; ACK = '0; CLR_ERR = 1'b0;
    @(negedge CLK);

    // Reset state; a write presented while in reset is lost.
    step(1'b1, 3'd1, 16'h5555, 5'b00000, 1'b0);
    RESET_N = 1'b1;

    // 1: single write to slot 2
    e.o[2] = 16'hBEEF; e.v = 5'b00100;
    step(1'b1, 3'd2, 16'hBEEF, 5'b00000, 1'b0);

    // 2: overrun on slot 0, then clear
    e.o[0] = 16'h1234; e.v = 5'b00101;
    step(1'b1, 3'd0, 16'h1234, 5'b00000, 1'b0);
    e.o[0] = 16'h5678; e.ovr = 5'b00001;
    step(1'b1, 3'd0, 16'h5678, 5'b00000, 1'b0);
    e.ovr = 5'b00000;
    step(1'b0, 3'd0, 16'h0000, 5'b00000, 1'b1);

    // 3: same-cycle write and ack on slot 3, then ack alone
    e.o[3] = 16'h1111; e.v = 5'b01101;
    step(1'b1, 3'd3, 16'h1111, 5'b00000, 1'b0);
    e.o[3] = 16'h00AA;
    step(1'b1, 3'd3, 16'h00AA, 5'b01000, 1'b0);
    e.v = 5'b00101;
    step(1'b0, 3'd3, 16'hFFFF, 5'b01000, 1'b0);
    // multiple acks; slot 1 is empty so its ack is ignored
    e.v = 5'b00100;
    step(1'b0, 3'd0, 16'h0000, 5'b00011, 1'b0);

    // 4: bad selects, first-error capture, clear racing a new error
    e.err = 1'b1; e.esel = 3'd6;
    step(1'b1, 3'd6, 16'hDEAD, 5'b00000, 1'b0);
    step(1'b1, 3'd7, 16'hDEAD, 5'b00000, 1'b0);
    e.esel = 3'd5;
    step(1'b1, 3'd5, 16'hDEAD, 5'b00000, 1'b1);
    e.err = 1'b0; e.esel = 3'd0;
    step(1'b0, 3'd0, 16'h0000, 5'b00000, 1'b1);
    // overrun in the same cycle as a clear: overrun wins
    e.o[2] = 16'hCAFE; e.ovr = 5'b00100;
    step(1'b1, 3'd2, 16'hCAFE, 5'b00000, 1'b1);
    e.ovr = 5'b00000;
    step(1'b0, 3'd0, 16'h0000, 5'b00000, 1'b1);

    // 5: fill all slots, then asynchronous reset between edges
    e.o[0] = 16'h0101; e.v = 5'b00101;
    step(1'b1, 3'd0, 16'h0101, 5'b00000, 1'b0);
    e.o[1] = 16'h0202; e.v = 5'b00111;
    step(1'b1, 3'd1, 16'h0202, 5'b00000, 1'b0);
    e.o[3] = 16'h0303; e.v = 5'b01111;
    step(1'b1, 3'd3, 16'h0303, 5'b00000, 1'b0);
    e.o[4] = 16'h0404; e.v = 5'b11111;
    step(1'b1, 3'd4, 16'h0404, 5'b00000, 1'b0);
    WE = 1'b0;
    #2;
    e = '0;
    step_id++;
    sb_q.push_back(e);
    id_q.push_back(step_id);
    RESET_N = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    e.o[4] = 16'hFFFF; e.v = 5'b10000;
    step(1'b1, 3'd4, 16'hFFFF, 5'b00000, 1'b0);
    WE = 1'b0;

    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge CLK);
    if (sb_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    if (n_checks < 12) begin
      n_fail++;
      $display("FAIL coverage: %0d comparisons, expected at least 12", n_checks);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
